// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1-style TAP controller with BYPASS, IDCODE and N_DR user data registers.
// Shift/update logic runs on posedge tck; tdo/tdo_en are launched on negedge tck.
module jtag_tap_ctrl #(
  parameter int          IR_W   = 4,
  parameter int          DR_W   = 32,
  parameter int          N_DR   = 2,
  parameter logic [31:0] IDCODE = 32'h1234_5ABD
) (
  input  logic                 tck,
  input  logic                 trst,
  input  logic                 tms,
  input  logic                 tdi,
  output logic                 tdo,
  output logic                 tdo_en,
  output logic [3:0]           tap_state,
  output logic [IR_W-1:0]      ir,
  input  logic [N_DR*DR_W-1:0] dr_capture_data,
  output logic [N_DR*DR_W-1:0] dr_update_data,
  output logic [N_DR-1:0]      dr_update_valid
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
    SH_DR  = 4'd4,  EX1_DR = 4'd5,  PA_DR  = 4'd6,  EX2_DR = 4'd7,
    UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
    EX1_IR = 4'd12, PA_IR  = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } state_t;

  localparam logic [IR_W-1:0] IDCODE_INSTR = IR_W'(1);
  localparam logic [IR_W-1:0] IR_CAPTURE   = IR_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [IR_W-1:0]   ir_sr;
  logic              bypass_sr;
  logic [31:0]       id_sr;
  logic [DR_W-1:0]   user_sr [N_DR];
  logic              id_sel;
  logic [N_DR-1:0]   user_sel;
  logic              sel_lsb;

  assign tap_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      TLR:     state_nxt = tms ? TLR    : RTI;
      RTI:     state_nxt = tms ? SEL_DR : RTI;
      SEL_DR:  state_nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR:  state_nxt = tms ? EX1_DR : SH_DR;
      SH_DR:   state_nxt = tms ? EX1_DR : SH_DR;
      EX1_DR:  state_nxt = tms ? UPD_DR : PA_DR;
      PA_DR:   state_nxt = tms ? EX2_DR : PA_DR;
      EX2_DR:  state_nxt = tms ? UPD_DR : SH_DR;
      UPD_DR:  state_nxt = tms ? SEL_DR : RTI;
      SEL_IR:  state_nxt = tms ? TLR    : CAP_IR;
      CAP_IR:  state_nxt = tms ? EX1_IR : SH_IR;
      SH_IR:   state_nxt = tms ? EX1_IR : SH_IR;
      EX1_IR:  state_nxt = tms ? UPD_IR : PA_IR;
      PA_IR:   state_nxt = tms ? EX2_IR : PA_IR;
      EX2_IR:  state_nxt = tms ? UPD_IR : SH_IR;
      UPD_IR:  state_nxt = tms ? SEL_DR : RTI;
      default: state_nxt = TLR;
    endcase
  end

  // Instruction decode; anything that is neither IDCODE nor a user code is BYPASS.
  always_comb begin
    id_sel   = (ir == IDCODE_INSTR);
    user_sel = '0;
    for (int k = 0; k < N_DR; k++) begin
      user_sel[k] = (ir == IR_W'(k + 2));
    end
  end

  always_comb begin
    sel_lsb = bypass_sr;
    if (id_sel) sel_lsb = id_sr[0];
    for (int k = 0; k < N_DR; k++) begin
      if (user_sel[k]) sel_lsb = user_sr[k][0];
    end
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      state           <= TLR;
      ir              <= IDCODE_INSTR;
      ir_sr           <= '0;
      bypass_sr       <= 1'b0;
      id_sr           <= '0;
      dr_update_data  <= '0;
      dr_update_valid <= '0;
      for (int k = 0; k < N_DR; k++) user_sr[k] <= '0;
    end else begin
      state           <= state_nxt;
      dr_update_valid <= '0;
      case (state)
        TLR:    ir    <= IDCODE_INSTR;
        CAP_IR: ir_sr <= IR_CAPTURE;
        SH_IR:  ir_sr <= {tdi, ir_sr[IR_W-1:1]};
        UPD_IR: ir    <= ir_sr;
        CAP_DR: begin
          bypass_sr <= 1'b0;
          id_sr     <= IDCODE;
          for (int k = 0; k < N_DR; k++) user_sr[k] <= dr_capture_data[k*DR_W +: DR_W];
        end
        SH_DR: begin
          if (id_sel) id_sr <= {tdi, id_sr[31:1]};
          else if (user_sel == '0) bypass_sr <= tdi;
          // Shift form works for DR_W == 1 as well.
          for (int k = 0; k < N_DR; k++) begin
            if (user_sel[k]) user_sr[k] <= (user_sr[k] >> 1) | (DR_W'(tdi) << (DR_W - 1));
          end
        end
        UPD_DR: begin
          for (int k = 0; k < N_DR; k++) begin
            if (user_sel[k]) begin
              dr_update_data[k*DR_W +: DR_W] <= user_sr[k];
              dr_update_valid[k]             <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(negedge tck or posedge trst) begin
    if (trst) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      case (state)
        SH_IR: begin
          tdo    <= ir_sr[0];
          tdo_en <= 1'b1;
        end
        SH_DR: begin
          tdo    <= sel_lsb;
          tdo_en <= 1'b1;
        end
        default: begin
          tdo    <= 1'b0;
          tdo_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
